// File: rtl/ledwater_seq_ctrl.sv
// ledwater_seq_ctrl: sequencer for a bank of LED_W water-light LEDs.
//   An internal prescaler divides clk_50M by TICK_DIV to make animation steps.
//   Four animation modes are available: FILL, DRAIN, CHASE and BOUNCE.
//   run is a level: 1 animates, 0 pauses. A pause freezes the step and the prescaler.
//   Mode changes use a req/ack handshake. One capture is made per assertion of mode_req.
// Ports:
//   clk_50M      system clock
//   rst          synchronous, active-high reset
//   run          1 = animate, 0 = pause
//   mode_req     mode-change request, held until mode_ack
//   mode_sel     requested mode (0 FILL, 1 DRAIN, 2 CHASE, 3 BOUNCE)
//   mode_ack     one-cycle pulse when the requested mode is loaded
//   step_tick    one-cycle pulse on each animation step
//   pattern_done one-cycle pulse when the step index wraps to 0
//   dataout      registered LED drive
// Build option: define LEDWATER_ACTIVE_HIGH_EN to drive 1 = lit (all zeros when idle).
//   By default the LEDs are active-low (all ones when idle).
module ledwater_seq_ctrl #(
  parameter int LED_W    = 12,
  parameter int TICK_DIV = 12500000
) (
  input  logic             clk_50M,
  input  logic             rst,
  input  logic             run,
  input  logic             mode_req,
  input  logic [1:0]       mode_sel,
  output logic             mode_ack,
  output logic             step_tick,
  output logic             pattern_done,
  output logic [LED_W-1:0] dataout
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(2*LED_W);   // the widest step index is the BOUNCE index 2N-3
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV-1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  typedef enum logic [1:0] {FILL, DRAIN, CHASE, BOUNCE} mode_t;

  state_t          state, state_n;
  mode_t           mode, mode_n, pend_sel, pend_sel_n;
  logic [SW-1:0]   step, step_n, last_step;
  logic [PW-1:0]   presc, presc_n;
  logic            pending, pending_n, armed, armed_n;
  logic            ack_n, tick_n, done_n;
  logic [LED_W-1:0] lit, drive, dout_n;
  int              bounce_idx;

`ifdef LEDWATER_ACTIVE_HIGH_EN
  localparam logic [LED_W-1:0] LED_OFF = '0;
  assign drive = lit;
`else
  localparam logic [LED_W-1:0] LED_OFF = '1;
  assign drive = ~lit;
`endif

  // Build the lit pattern bit by bit from the current mode and step.
  always_comb begin
    lit = '0;
    bounce_idx = (int'(step) < LED_W) ? int'(step) : 2*LED_W - 2 - int'(step);
    for (int i = 0; i < LED_W; i++) begin
      case (mode)
        FILL:    lit[i] = (i < int'(step));
        DRAIN:   lit[i] = (i < LED_W - int'(step));
        CHASE:   lit[i] = (i == int'(step));
        default: lit[i] = (i == bounce_idx);
      endcase
    end
  end

  always_comb begin
    case (mode)
      FILL, DRAIN: last_step = SW'(LED_W);
      CHASE:       last_step = SW'(LED_W - 1);
      default:     last_step = SW'(2*LED_W - 3);
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state        <= IDLE;
      mode         <= FILL;
      step         <= '0;
      presc        <= '0;
      pending      <= 1'b0;
      pend_sel     <= FILL;
      armed        <= 1'b1;
      mode_ack     <= 1'b0;
      step_tick    <= 1'b0;
      pattern_done <= 1'b0;
      dataout      <= LED_OFF;
    end else begin
      state        <= state_n;
      mode         <= mode_n;
      step         <= step_n;
      presc        <= presc_n;
      pending      <= pending_n;
      pend_sel     <= pend_sel_n;
      armed        <= armed_n;
      mode_ack     <= ack_n;
      step_tick    <= tick_n;
      pattern_done <= done_n;
      dataout      <= dout_n;
    end
  end

  always_comb begin
    state_n    = state;
    mode_n     = mode;
    step_n     = step;
    presc_n    = presc;
    pending_n  = pending;
    pend_sel_n = pend_sel;
    armed_n    = armed;
    ack_n      = 1'b0;
    tick_n     = 1'b0;
    done_n     = 1'b0;
    // dataout follows the step register one cycle later.
    dout_n     = (state == IDLE) ? LED_OFF : drive;

    // armed re-arms only when mode_req is seen low. A request held through its ack
    // is therefore captured only once.
    if (!mode_req) armed_n = 1'b1;
    if (mode_req && !pending && armed) begin
      pend_sel_n = mode_t'(mode_sel);
      pending_n  = 1'b1;
      armed_n    = 1'b0;
    end

    case (state)
      RUN: begin
        if (presc == PRESC_LAST) begin
          presc_n = '0;
          tick_n  = 1'b1;
          if (pending) begin
            // A pending change takes this tick in place of a normal advance.
            mode_n    = pend_sel;
            step_n    = '0;
            pending_n = 1'b0;
            ack_n     = 1'b1;
          end else if (step == last_step) begin
            step_n = '0;
            done_n = 1'b1;
          end else begin
            step_n = step + 1'b1;
          end
        end else begin
          presc_n = presc + 1'b1;
        end
        // The tick in this cycle still completes before the pause takes effect.
        if (!run) state_n = PAUSE;
      end
      default: begin
        // IDLE or PAUSE: a pending change applies at once and holds the state.
        if (pending) begin
          mode_n    = pend_sel;
          step_n    = '0;
          presc_n   = '0;
          pending_n = 1'b0;
          ack_n     = 1'b1;
        end else if (run) begin
          state_n = RUN;
          if (state == IDLE) begin
            step_n  = '0;
            presc_n = '0;
          end
        end
      end
    endcase
  end
endmodule

// File: tb/tb_ledwater_seq_ctrl.sv
// Self-checking bench for ledwater_seq_ctrl (LED_W=12, TICK_DIV=4).
// The reference model computes the patterns arithmetically from the mode rules.
// It is advanced once per clock edge from the same inputs that the DUT sees.
module tb_ledwater_seq_ctrl;
  localparam int N  = 12;
  localparam int TD = 4;

  logic         clk_50M = 1'b0;
  logic         rst = 1'b1, run = 1'b0, mode_req = 1'b0;
  logic [1:0]   mode_sel = 2'd0;
  logic         mode_ack, step_tick, pattern_done;
  logic [N-1:0] dataout;

  int checks = 0;
  int errors = 0;

  ledwater_seq_ctrl #(.LED_W(N), .TICK_DIV(TD)) dut (
    .clk_50M(clk_50M), .rst(rst), .run(run), .mode_req(mode_req), .mode_sel(mode_sel),
    .mode_ack(mode_ack), .step_tick(step_tick), .pattern_done(pattern_done), .dataout(dataout)
  );

  always #5 clk_50M = ~clk_50M;

  // ---------------- reference model ----------------
  // ms: 0 idle, 1 running, 2 paused
  int ms = 0, mm = 0, mk = 0, mp = 0, mpsel = 0;
  bit mpend = 0, marm = 1, mack = 0, mtick = 0, mdone = 0;
  logic [N-1:0] mdout = '1;

  function automatic logic [N-1:0] pat(int m, int k);
    logic [N:0] w;
    case (m)
      0: w = (13'd1 << k) - 13'd1;
      1: w = {1'b0, 12'hFFF} >> k;
      2: w = 13'd1 << k;
      default: w = 13'd1 << ((k < N) ? k : 2*N - 2 - k);
    endcase
    return w[N-1:0];
  endfunction

`ifdef LEDWATER_ACTIVE_HIGH_EN
  function automatic logic [N-1:0] led(logic [N-1:0] p); return p; endfunction
  localparam logic [N-1:0] OFF = '0;
`else
  function automatic logic [N-1:0] led(logic [N-1:0] p); return ~p; endfunction
  localparam logic [N-1:0] OFF = '1;
`endif

  function automatic int period(int m);
    return (m < 2) ? N + 1 : (m == 2) ? N : 2*N - 2;
  endfunction

  task automatic model_update();
    int ns = ms, nm = mm, nk = mk, np = mp, npsel = mpsel;
    bit npend = mpend, narm = marm, nack = 0, ntick = 0, ndone = 0;
    if (rst) begin
      ms = 0; mm = 0; mk = 0; mp = 0; mpsel = 0; mpend = 0; marm = 1;
      mack = 0; mtick = 0; mdone = 0; mdout = OFF;
      return;
    end
    mdout = (ms == 0) ? OFF : led(pat(mm, mk));
    if (!mode_req) narm = 1;
    if (mode_req && !mpend && marm) begin npsel = int'(mode_sel); npend = 1; narm = 0; end
    if (ms == 1) begin
      if (mp == TD - 1) begin
        np = 0; ntick = 1;
        if (mpend) begin nm = mpsel; nk = 0; npend = 0; nack = 1; end
        else if (mk == period(mm) - 1) begin nk = 0; ndone = 1; end
        else nk = mk + 1;
      end else np = mp + 1;
      if (!run) ns = 2;
    end else if (mpend) begin
      nm = mpsel; nk = 0; np = 0; npend = 0; nack = 1;
    end else if (run) begin
      ns = 1;
      if (ms == 0) begin nk = 0; np = 0; end
    end
    ms = ns; mm = nm; mk = nk; mp = np; mpsel = npsel; mpend = npend; marm = narm;
    mack = nack; mtick = ntick; mdone = ndone;
  endtask

  task automatic clk1();
    @(posedge clk_50M);
    model_update();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; run = 0; mode_req = 0;
    clk1(); clk1();
    checks++;
    if (dataout !== 12'hFFF && OFF == 12'hFFF || dataout !== OFF) begin
      errors++; $display("FAIL reset_dataout got %h exp %h", dataout, OFF);
    end
    checks++;
    if ({mode_ack, step_tick, pattern_done} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses got %b%b%b exp 000", mode_ack, step_tick, pattern_done);
    end
    rst = 0;
  endtask

  task automatic test_fill();
    int tk = 0, done_cnt = 0;
    bit chk_next = 0;
    run = 1;
    for (int c = 0; c < 110; c++) begin
      clk1();
      checks++;
      if ({dataout, mode_ack, step_tick, pattern_done} !== {mdout, mack, mtick, mdone}) begin
        errors++;
        $display("FAIL fill c=%0d got %h %b%b%b exp %h %b%b%b", c, dataout, mode_ack, step_tick,
                 pattern_done, mdout, mack, mtick, mdone);
      end
      if (chk_next) begin
        logic [N-1:0] e;
        e = led(12'hFFF >> (N - (tk % 13)) & 12'hFFF);
        if (tk % 13 == 0) e = OFF;
        checks++;
        if (dataout !== e) begin
          errors++; $display("FAIL fill_seq tick=%0d got %h exp %h", tk, dataout, e);
        end
        chk_next = 0;
      end
      if (step_tick === 1'b1) begin tk++; chk_next = 1; end
      if (step_tick === 1'b1 && pattern_done === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt != 2) begin
      errors++; $display("FAIL fill_wraps got %0d exp 2", done_cnt);
    end
  endtask

  task automatic test_chase();
    rst = 1; run = 0; clk1(); rst = 0;
    mode_req = 1; mode_sel = 2;
    clk1();
    checks++;
    if (mode_ack !== 1'b0) begin errors++; $display("FAIL chase_ack_early got %b exp 0", mode_ack); end
    clk1();
    checks++;
    if (mode_ack !== 1'b1) begin errors++; $display("FAIL chase_ack got %b exp 1", mode_ack); end
    mode_req = 0; run = 1;
    for (int c = 0; c < 2*N*TD + 8; c++) begin
      clk1();
      checks++;
      if ({dataout, mode_ack, step_tick, pattern_done} !== {mdout, mack, mtick, mdone}) begin
        errors++;
        $display("FAIL chase c=%0d got %h %b%b%b exp %h %b%b%b", c, dataout, mode_ack, step_tick,
                 pattern_done, mdout, mack, mtick, mdone);
      end
    end
  endtask

  task automatic test_bounce_drain();
    int sels[2] = '{3, 1};
    int lens[2] = '{2*(2*N-2)*TD + 8, (N+1)*TD + 8};
    for (int s = 0; s < 2; s++) begin
      int w = 0;
      mode_req = 1; mode_sel = 2'(sels[s]);
      while (!mack && w < 20) begin clk1(); w++; end
      checks++;
      if (!mack || mode_ack !== 1'b1) begin
        errors++; $display("FAIL bounce_drain_ack sel=%0d got %b exp 1", sels[s], mode_ack);
      end
      mode_req = 0;
      for (int c = 0; c < lens[s]; c++) begin
        clk1();
        checks++;
        if ({dataout, mode_ack, step_tick, pattern_done} !== {mdout, mack, mtick, mdone}) begin
          errors++;
          $display("FAIL mode%0d c=%0d got %h %b%b%b exp %h %b%b%b", sels[s], c, dataout, mode_ack,
                   step_tick, pattern_done, mdout, mack, mtick, mdone);
        end
      end
    end
  endtask

  task automatic test_pause();
    int w = 0, tcount = 0;
    while (mp != 1 && w < 10) begin clk1(); w++; end
    run = 0;
    for (int c = 0; c < 10; c++) begin
      clk1();
      if (step_tick === 1'b1 && c > 0) tcount++;
      checks++;
      if ({dataout, mode_ack, step_tick, pattern_done} !== {mdout, mack, mtick, mdone}) begin
        errors++;
        $display("FAIL pause c=%0d got %h %b%b%b exp %h %b%b%b", c, dataout, mode_ack, step_tick,
                 pattern_done, mdout, mack, mtick, mdone);
      end
    end
    checks++;
    if (tcount != 0) begin errors++; $display("FAIL pause_ticks got %0d exp 0", tcount); end
    run = 1;
    for (int c = 0; c < 20; c++) begin
      clk1();
      checks++;
      if ({dataout, mode_ack, step_tick, pattern_done} !== {mdout, mack, mtick, mdone}) begin
        errors++;
        $display("FAIL resume c=%0d got %h %b%b%b exp %h %b%b%b", c, dataout, mode_ack, step_tick,
                 pattern_done, mdout, mack, mtick, mdone);
      end
    end
  endtask

  task automatic test_handshake();
    int acks = 0;
    mode_req = 1; mode_sel = 2;
    for (int c = 0; c < 30; c++) begin
      clk1();
      if (mode_ack === 1'b1) acks++;
      checks++;
      if ({dataout, mode_ack, step_tick, pattern_done} !== {mdout, mack, mtick, mdone}) begin
        errors++;
        $display("FAIL hold c=%0d got %h %b%b%b exp %h %b%b%b", c, dataout, mode_ack, step_tick,
                 pattern_done, mdout, mack, mtick, mdone);
      end
    end
    checks++;
    if (acks != 1) begin errors++; $display("FAIL hold_acks got %0d exp 1", acks); end
    // Second request raised while the first is still pending.
    mode_req = 0; clk1();
    mode_req = 1; mode_sel = 1; clk1();
    mode_req = 0; clk1();
    mode_req = 1; mode_sel = 3;
    for (int c = 0; c < 24; c++) begin
      clk1();
      if (mack) mode_req = 0;
      checks++;
      if ({dataout, mode_ack, step_tick, pattern_done} !== {mdout, mack, mtick, mdone}) begin
        errors++;
        $display("FAIL second c=%0d got %h %b%b%b exp %h %b%b%b", c, dataout, mode_ack, step_tick,
                 pattern_done, mdout, mack, mtick, mdone);
      end
    end
    mode_req = 0;
  endtask

  task automatic test_reset_mid();
    int w = 0;
    rst = 1; clk1(); rst = 0; run = 1;
    while (!(ms == 1 && mk == 5) && w < 60) begin clk1(); w++; end
    checks++;
    if (mk != 5) begin errors++; $display("FAIL reset_mid_reach got %0d exp 5", mk); end
    mode_req = 1; mode_sel = 3; clk1();
    rst = 1; clk1();
    checks++;
    if (dataout !== OFF || mode_ack !== 1'b0) begin
      errors++; $display("FAIL reset_mid got %h %b exp %h 0", dataout, mode_ack, OFF);
    end
    rst = 0; mode_req = 0;
    for (int c = 0; c < 3*TD + 4; c++) begin
      clk1();
      checks++;
      if ({dataout, mode_ack, step_tick, pattern_done} !== {mdout, mack, mtick, mdone}) begin
        errors++;
        $display("FAIL restart c=%0d got %h %b%b%b exp %h %b%b%b", c, dataout, mode_ack, step_tick,
                 pattern_done, mdout, mack, mtick, mdone);
      end
    end
    // Step 1 of FILL (not BOUNCE) shows the discarded request had no effect.
    checks++;
    if (dataout !== led(12'h001) && dataout !== led(12'h003) && dataout !== led(12'h007)) begin
      errors++; $display("FAIL restart_mode got %h exp FILL pattern", dataout);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) == 0) run = ~run;
      if (mode_req && (mack || $urandom_range(0, 15) == 0)) mode_req = 0;
      else if (!mode_req && $urandom_range(0, 19) == 0) begin
        mode_req = 1; mode_sel = 2'($urandom_range(0, 3));
      end
      clk1();
      checks++;
      if ({dataout, mode_ack, step_tick, pattern_done} !== {mdout, mack, mtick, mdone}) begin
        errors++;
        $display("FAIL random c=%0d got %h %b%b%b exp %h %b%b%b", c, dataout, mode_ack, step_tick,
                 pattern_done, mdout, mack, mtick, mdone);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_chase();
    test_bounce_drain();
    test_pause();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
